// File: rtl/imem_cache_if.sv
// Fetch-side and refill-side signals of the direct-mapped instruction cache.
// slave is the cache's view; master is the fetch stage plus backing memory.
interface imem_cache_if #(
  parameter int WORD = 32,
  parameter int ADDR = 16
);
  logic [ADDR-1:0] addr_i;
  logic [WORD-1:0] inst_o;
  logic            stall_o;
  logic            flush_i;
  logic            mem_req_o;
  logic [ADDR-1:0] mem_addr_o;
  logic            mem_ack_i;
  logic [WORD-1:0] mem_data_i;

  modport slave (
    input  addr_i,
    input  flush_i,
    input  mem_ack_i,
    input  mem_data_i,
    output inst_o,
    output stall_o,
    output mem_req_o,
    output mem_addr_o
  );

  modport master (
    output addr_i,
    output flush_i,
    output mem_ack_i,
    output mem_data_i,
    input  inst_o,
    input  stall_o,
    input  mem_req_o,
    input  mem_addr_o
  );
endinterface

// File: rtl/imem_cache.sv
// Direct-mapped single-word-line instruction cache with a two-state
// refill FSM; hits are answered combinationally in the same cycle.
module imem_cache #(
  parameter int WORD  = 32,
  parameter int ADDR  = 16,
  parameter int LINES = 16
) (
  input logic        clk,
  input logic        rst,
  imem_cache_if.slave bus
);
  localparam int IDX = $clog2(LINES);
  localparam int TAG = ADDR - IDX;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t           state;
  logic [LINES-1:0] valid;
  logic [TAG-1:0]   tag_q  [LINES];
  logic [WORD-1:0]  data_q [LINES];
  logic             discard;
  logic             req;
  logic [ADDR-1:0]  maddr;

  logic [IDX-1:0] idx;
  logic [TAG-1:0] tag;
  logic [IDX-1:0] fidx;
  logic [TAG-1:0] ftag;
  logic           hit;

  assign idx  = bus.addr_i[IDX-1:0];
  assign tag  = bus.addr_i[ADDR-1:IDX];
  assign fidx = maddr[IDX-1:0];
  assign ftag = maddr[ADDR-1:IDX];

  assign hit = (state == IDLE) && valid[idx] &&
               (tag_q[idx] == tag) && !bus.flush_i;

  assign bus.stall_o    = !hit;
  assign bus.inst_o     = hit ? data_q[idx] : '0;
  assign bus.mem_req_o  = req;
  assign bus.mem_addr_o = maddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid   <= '0;
      discard <= 1'b0;
      req     <= 1'b0;
      maddr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          discard <= 1'b0;
          if (bus.flush_i) begin
            valid <= '0;
          end else if (!hit) begin
            state <= FILL;
            req   <= 1'b1;
            maddr <= bus.addr_i;
          end
        end
        FILL: begin
          if (bus.flush_i) valid <= '0;
          if (bus.mem_ack_i) begin
            // a flush seen at any point of this refill keeps the line invalid
            if (!bus.flush_i && !discard) valid[fidx] <= 1'b1;
            state   <= IDLE;
            req     <= 1'b0;
            discard <= 1'b0;
          end else if (bus.flush_i) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == FILL && bus.mem_ack_i) begin
      data_q[fidx] <= bus.mem_data_i;
      tag_q[fidx]  <= ftag;
    end
  end
endmodule

// File: doc/imem_cache.md
IMEM_CACHE -- requirements
Module: imem_cache

Interface
REQ-001 Parameter WORD, default 32, instruction width in bits.
REQ-002 Parameter ADDR, default 16, word-address width in bits.
REQ-003 Parameter LINES, default 16, number of direct-mapped lines; power of two, at least 2; IDX = log2(LINES), TAG = ADDR - IDX.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; one clock, synchronous, active-high.
REQ-006 addr_i  in  ADDR  fetch word address from the fetch stage.
REQ-007 inst_o  out  WORD  instruction at addr_i; meaningful only when stall_o = 0.
REQ-008 stall_o  out  1  high when inst_o is not valid for addr_i; drives the fetch-stage stall.
REQ-009 flush_i  in  1  invalidate all lines.
REQ-010 mem_req_o  out  1  refill request to backing memory.
REQ-011 mem_addr_o  out  ADDR  refill word address.
REQ-012 mem_ack_i  in  1  backing memory returns data this cycle.
REQ-013 mem_data_i  in  WORD  refill data, sampled when mem_ack_i = 1.

Function
REQ-014 Each line holds a valid bit, a TAG-bit tag and a WORD-bit data entry; index = addr_i[IDX-1:0], tag = addr_i[ADDR-1:IDX].
REQ-015 Hit = state IDLE, line valid, stored tag equal to the addr_i tag, and flush_i = 0.
REQ-016 inst_o and stall_o are combinational from addr_i: on a hit, inst_o = line data in the same cycle and stall_o = 0; otherwise stall_o = 1 and inst_o = 0.
REQ-017 The FSM has two states: IDLE and FILL.
REQ-018 IDLE -> FILL on a miss with flush_i = 0; the miss address is latched into mem_addr_o at that edge.
REQ-019 In FILL: mem_req_o = 1 and stall_o = 1; mem_addr_o holds stable until the ack.
REQ-020 FILL -> IDLE on the edge where mem_ack_i = 1; the line at the latched index receives mem_data_i and the latched tag, and its valid bit is set.
REQ-021 mem_req_o is a Moore output of FILL, so it is low in IDLE; mem_ack_i is ignored in IDLE.
REQ-022 Minimum miss penalty: miss in cycle N, request in N+1, ack in N+1, hit with stall_o = 0 in N+2.
REQ-023 If addr_i changes during FILL, the latched address is still refilled; addr_i is re-evaluated in IDLE.
REQ-024 flush_i in IDLE clears all valid bits at the edge; stall_o = 1 during the flush cycle; no request is issued that cycle.
REQ-025 flush_i in FILL clears all valid bits; the outstanding request runs until ack; the returned data is written but the line stays invalid (sticky discard flag, cleared on return to IDLE).
REQ-026 flush_i coincident with mem_ack_i: flush wins; the line is not validated.
REQ-027 On a same-index, different-tag miss, the old line is replaced on refill.

Reset
REQ-028 When rst = 1 at an edge: state = IDLE, all valid bits = 0, discard flag = 0, mem_req_o = 0, mem_addr_o = 0.
REQ-029 The data and tag arrays are not reset; inst_o = 0 and stall_o = 1 after reset until the first refill completes.
REQ-030 rst asserted during FILL abandons the request: mem_req_o = 0 from the next cycle, and a later mem_ack_i in IDLE is ignored.

Verification
REQ-031 Cold miss: after reset, addr_i = 0x0010, ack on the first request cycle with data 0xDEADBEEF -> mem_addr_o = 0x0010; stall_o falls two cycles after the miss; inst_o = 0xDEADBEEF.
REQ-032 Ack delayed 5 cycles -> mem_req_o high and mem_addr_o stable for 5 cycles; stall_o = 1 throughout; hit the cycle after the ack.
REQ-033 Conflict: fill 0x0003 (data 0x11111111), then 0x0013 (0x22222222), then 0x0003 -> the third access misses again and returns 0x11111111 after refill.
REQ-034 flush_i pulsed during FILL for 0x0020 -> the ack completes; the next cycle misses again on 0x0020 and issues a new request.
REQ-035 rst pulsed during FILL, then a stray mem_ack_i -> mem_req_o = 0; no line is valid; addr_i misses.
REQ-036 Sequential hits 0x0000-0x000F after warm-up -> stall_o = 0 every cycle; inst_o matches the preloaded data.
